// File: rtl/comparator_scan_sequencer.sv
// comparator_scan_sequencer: walks halfstrips firing test pulses and publishes the expected comparator response.
// Optional macro SCAN_TIMEOUT_EN ends the scan with a sticky timeout when the injector never acknowledges.
module comparator_scan_sequencer #(
    parameter int SETTLE_CYCLES = 8,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_pulses,
    input  logic [4:0]  strip_first,
    input  logic [4:0]  strip_last,
    input  logic        pulser_ready,
    output logic        fire_pulse,
    output logic [31:0] halfstrips_expect,
    output logic        compout_expect,
    output logic [4:0]  strip_idx,
    output logic [15:0] pulse_cnt,
    output logic        busy,
    output logic        done,
    output logic        timeout
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETTLE    = 3'd1;
    localparam logic [2:0] FIRE      = 3'd2;
    localparam logic [2:0] WAIT_ACK  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] NEXT      = 3'd5;
    localparam logic [2:0] FINISH    = 3'd6;

    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] ACK_LIM    = 8'(ACK_TIMEOUT - 1);

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [15:0] np;
    logic [4:0]  last;

    assign busy              = state != IDLE;
    assign fire_pulse        = state == FIRE && pulser_ready && !abort;
    assign done              = state == FINISH && !abort;
    assign compout_expect    = busy;
    assign halfstrips_expect = busy ? 32'h1 << strip_idx : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            np        <= '0;
            last      <= '0;
            strip_idx <= '0;
            pulse_cnt <= '0;
        end else if (abort && busy) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    np        <= num_pulses;
                    last      <= strip_last;
                    strip_idx <= strip_first;
                    pulse_cnt <= '0;
                    cnt       <= '0;
                    state     <= (num_pulses == 16'd0 || strip_first > strip_last) ? FINISH : SETTLE;
                end
                SETTLE: begin
                    cnt <= (cnt == SETTLE_LIM) ? 8'd0 : cnt + 8'd1;
                    if (cnt == SETTLE_LIM) state <= FIRE;
                end
                FIRE: if (pulser_ready) state <= WAIT_ACK;
                WAIT_ACK: if (!pulser_ready) state <= WAIT_DONE;
`ifdef SCAN_TIMEOUT_EN
                    else if (cnt == ACK_LIM) state <= FINISH;
`endif
                    else if (cnt != ACK_LIM) cnt <= cnt + 8'd1;
                WAIT_DONE: if (pulser_ready) begin
                    pulse_cnt <= pulse_cnt + 16'd1;
                    state     <= NEXT;
                end
                NEXT: begin
                    cnt <= '0;
                    if (pulse_cnt < np) state <= SETTLE;
                    else if (strip_idx < last) begin
                        strip_idx <= strip_idx + 5'd1;
                        pulse_cnt <= '0;
                        state     <= SETTLE;
                    end else state <= FINISH;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCAN_TIMEOUT_EN
    // Sticky until the next accepted start so software can read it after done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout <= 1'b0;
        else if (state == IDLE && start) timeout <= 1'b0;
        else if (state == WAIT_ACK && pulser_ready && cnt == ACK_LIM && !abort) timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_comparator_scan_sequencer.sv
// tb_comparator_scan_sequencer: vector table, directed corner sequences and random scans
// checked against a scan-list model (one expected halfstrip word per injection).
module tb_comparator_scan_sequencer;
    localparam int SETTLE_T = 3;
    localparam int ACK_T    = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_pulses = '0;
    logic [4:0]  strip_first = '0;
    logic [4:0]  strip_last = '0;
    logic        pulser_ready = 1'b1;
    logic        fire_pulse, compout_expect, busy, done, timeout;
    logic [31:0] halfstrips_expect;
    logic [4:0]  strip_idx;
    logic [15:0] pulse_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0, fires = 0, dones = 0, fire_cyc = 0, done_cyc = 0;
    int inj_low = 6;
    int low_left = 0;
    bit inj_dead = 1'b0;
    bit pend = 1'b0;
    logic [31:0] hs_log[$];

    typedef struct {
        logic [15:0] np;
        logic [4:0]  sf;
        logic [4:0]  sl;
        int          fires;
    } vec_t;
    vec_t vecs[8];

    comparator_scan_sequencer #(.SETTLE_CYCLES(SETTLE_T), .ACK_TIMEOUT(ACK_T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_pulses(num_pulses), .strip_first(strip_first), .strip_last(strip_last),
        .pulser_ready(pulser_ready), .fire_pulse(fire_pulse),
        .halfstrips_expect(halfstrips_expect), .compout_expect(compout_expect),
        .strip_idx(strip_idx), .pulse_cnt(pulse_cnt), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Monitor and injector model: ready drops the clock after a fire and stays low inj_low clocks.
    always @(negedge clk) begin
        logic f;
        f = fire_pulse;
        cyc++;
        if (f) begin
            fires++;
            fire_cyc = cyc;
            hs_log.push_back(halfstrips_expect);
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        if (low_left != 0) begin
            low_left--;
            if (low_left == 0) pulser_ready = 1'b1;
        end else if (pend) begin
            pend = 1'b0;
            pulser_ready = 1'b0;
            low_left = inj_low;
        end
        if (f && !inj_dead) pend = 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input logic [15:0] np, input logic [4:0] sf, input logic [4:0] sl,
                            input string nm, input bit restart);
        logic [31:0] exp_q[$];
        int f0, d0, h0, st, budget;
        bit degen;
        for (int s = int'(sf); s <= int'(sl); s++)
            for (int p = 0; p < int'(np); p++) exp_q.push_back(32'h1 << s);
        degen = exp_q.size() == 0;
        f0 = fires; d0 = dones; h0 = hs_log.size(); st = cyc;
        num_pulses = np; strip_first = sf; strip_last = sl; start = 1'b1;
        step();
        start = 1'b0;
        if (!degen) begin
            chk({nm, "_busy"}, 64'(busy), 64'd1);
            chk({nm, "_hs_first"}, 64'(halfstrips_expect), 64'(32'h1 << sf));
            chk({nm, "_compout"}, 64'(compout_expect), 64'd1);
        end
        if (restart && !degen) begin
            num_pulses = 16'd9; strip_first = 5'd0; strip_last = 5'd31; start = 1'b1;
            step();
            start = 1'b0;
        end
        budget = 60 * (exp_q.size() + 1);
        while (dones == d0 && budget > 0) begin
            step();
            budget--;
        end
        chk({nm, "_done_in_time"}, 64'(budget > 0), 64'd1);
        step();
        step();
        chk({nm, "_fire_count"}, 64'(fires - f0), 64'(exp_q.size()));
        chk({nm, "_done_count"}, 64'(dones - d0), 64'd1);
        for (int i = 0; i < exp_q.size(); i++)
            if (h0 + i < hs_log.size()) chk($sformatf("%s_hs%0d", nm, i), 64'(hs_log[h0 + i]), 64'(exp_q[i]));
        chk({nm, "_idle"}, 64'({busy, compout_expect, halfstrips_expect}), 64'd0);
        chk({nm, "_timeout"}, 64'(timeout), 64'd0);
        if (degen) chk({nm, "_done_latency"}, 64'(done_cyc - st), 64'd2);
        else chk({nm, "_final"}, 64'({strip_idx, pulse_cnt}), 64'({sl, np}));
    endtask

    initial begin
        int f, d, budget;
        vecs[0] = '{16'd2, 5'd3,  5'd4,  4};
        vecs[1] = '{16'd0, 5'd3,  5'd4,  0};
        vecs[2] = '{16'd2, 5'd5,  5'd2,  0};
        vecs[3] = '{16'd1, 5'd31, 5'd31, 1};
        vecs[4] = '{16'd3, 5'd0,  5'd0,  3};
        vecs[5] = '{16'd1, 5'd0,  5'd3,  4};
        vecs[6] = '{16'd1, 5'd28, 5'd31, 4};
        vecs[7] = '{16'd4, 5'd10, 5'd11, 8};

        repeat (3) step();
        chk("reset_outputs", 64'({fire_pulse, busy, done, timeout, compout_expect, strip_idx, pulse_cnt, halfstrips_expect}), 64'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("no_self_start", 64'(busy), 64'd0);

        foreach (vecs[i]) begin
            f = fires;
            run_scan(vecs[i].np, vecs[i].sf, vecs[i].sl, $sformatf("vec%0d", i), 1'b0);
            chk($sformatf("vec%0d_table_fires", i), 64'(fires - f), 64'(vecs[i].fires));
        end

        run_scan(16'd2, 5'd3, 5'd4, "start_while_busy", 1'b1);

        // Abort while the second injection is still in progress.
        inj_low = 6;
        f = fires; d = dones;
        num_pulses = 16'd2; strip_first = 5'd3; strip_last = 5'd4; start = 1'b1;
        step();
        start = 1'b0;
        budget = 200;
        while (!(fires == f + 2 && !pulser_ready) && budget > 0) begin
            step();
            budget--;
        end
        chk("abort_reached_wait_done", 64'(budget > 0), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hold", 64'({strip_idx, pulse_cnt}), 64'({5'd3, 16'd1}));
        repeat (40) step();
        chk("abort_no_more_fire", 64'(fires - f), 64'd2);
        chk("abort_no_done", 64'(dones - d), 64'd0);
        run_scan(16'd2, 5'd3, 5'd4, "post_abort", 1'b0);

        // Asynchronous reset in the middle of SETTLE.
        num_pulses = 16'd2; strip_first = 5'd5; strip_last = 5'd6; start = 1'b1;
        step();
        start = 1'b0;
        chk("pre_reset_busy", 64'({busy, halfstrips_expect}), 64'({1'b1, 32'h20}));
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({fire_pulse, busy, done, timeout, compout_expect, strip_idx, pulse_cnt, halfstrips_expect}), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("reset_release_idle", 64'(busy), 64'd0);

        inj_dead = 1'b1;
        f = fires; d = dones;
        num_pulses = 16'd1; strip_first = 5'd0; strip_last = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        budget = 100;
        while (dones == d && budget > 0) begin
            step();
            budget--;
        end
        chk("to_done_in_time", 64'(budget > 0), 64'd1);
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_latency", 64'(done_cyc - fire_cyc), 64'(ACK_T + 1));
        chk("to_single_fire", 64'(fires - f), 64'd1);
        step();
        chk("to_idle_sticky", 64'({busy, timeout}), 64'b01);
        inj_dead = 1'b0;
        run_scan(16'd1, 5'd2, 5'd2, "after_timeout", 1'b0);
`else
        repeat (4 * ACK_T + 40) step();
        chk("noto_still_busy", 64'({busy, timeout}), 64'b10);
        chk("noto_no_done", 64'(dones - d), 64'd0);
        chk("noto_single_fire", 64'(fires - f), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("noto_abort_idle", 64'(busy), 64'd0);
        inj_dead = 1'b0;
`endif

        for (int k = 0; k < 8; k++) begin
            int sfi, sli;
            inj_low = int'($urandom_range(1, 8));
            sfi = int'($urandom_range(0, 31));
            sli = sfi + int'($urandom_range(0, 2));
            if (sli > 31) sli = 31;
            if ($urandom_range(0, 4) == 0) sli = sfi - 1;
            run_scan(16'($urandom_range(0, 3)), 5'(sfi), 5'(sli), $sformatf("rnd%0d", k), 1'(k % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comparator_scan_sequencer.md
COMPARATOR_SCAN_SEQUENCER -- requirements
Module: comparator_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8, idle clocks between end of one injection and next fire_pulse (range 1..255).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, max clocks to wait for pulser_ready to fall after fire_pulse (range 1..255).
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a scan.
- abort  in  1  stop scan, return to idle.
- num_pulses  in  16  injections per halfstrip.
- strip_first  in  5  first halfstrip index.
- strip_last  in  5  last halfstrip index, inclusive.
- pulser_ready  in  1  injector ready; low while injection in progress.
- fire_pulse  out  1  injection request to injector.
- halfstrips_expect  out  32  expected halfstrip pattern for current injection.
- compout_expect  out  1  expected comparator output.
- strip_idx  out  5  current halfstrip.
- pulse_cnt  out  16  injections completed on current strip.
- busy  out  1  scan in progress.
- done  out  1  one-cycle scan-complete pulse.
- timeout  out  1  sticky; injector failed to acknowledge.

Function
REQ-004 SHALL implement states IDLE, SETTLE, FIRE, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
REQ-005 IDLE: on start=1, SHALL latch num_pulses, strip_first, strip_last; set strip_idx=strip_first, pulse_cnt=0, clear timeout; go SETTLE. Other inputs ignored.
REQ-006 IDLE with start=1 and (num_pulses==0 or strip_first>strip_last) SHALL go FINISH directly; no fire_pulse issued.
REQ-007 SETTLE: SHALL count SETTLE_CYCLES clocks, then go FIRE.
REQ-008 FIRE: SHALL wait for pulser_ready=1, then assert fire_pulse for exactly one clock and go WAIT_ACK.
REQ-009 WAIT_ACK: pulser_ready=0 SHALL go WAIT_DONE; otherwise count clocks per REQ-019.
REQ-010 WAIT_DONE: pulser_ready=1 SHALL increment pulse_cnt and go NEXT.
REQ-011 NEXT: if pulse_cnt<num_pulses SHALL go SETTLE; else if strip_idx<strip_last SHALL increment strip_idx, zero pulse_cnt, go SETTLE; else go FINISH.
REQ-012 FINISH: SHALL assert done one clock, go IDLE.
REQ-013 halfstrips_expect SHALL equal 32'h1 << strip_idx while busy, 0 otherwise; compout_expect SHALL equal 1 while busy, 0 otherwise.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 start while busy SHALL be ignored.
REQ-016 abort=1 in any non-IDLE state SHALL go IDLE next clock, deassert fire_pulse, not pulse done; strip_idx/pulse_cnt hold last values. abort has priority over start in the same clock.
REQ-017 pulse_cnt SHALL not wrap; num_pulses=16'hFFFF yields 65535 injections per strip.
REQ-018 strip_last=31 SHALL terminate after strip 31 without strip_idx wrapping.

Reset
REQ-019 (see Configuration) reserved for timeout behaviour.
REQ-020 rst_n=0 SHALL immediately force state IDLE; fire_pulse, busy, done, timeout=0; strip_idx, pulse_cnt=0; halfstrips_expect=0; compout_expect=0; counters cleared, including mid-scan.
REQ-021 Release of rst_n SHALL not by itself start a scan.

Configuration
REQ-022 Macro SCAN_TIMEOUT_EN: when defined, WAIT_ACK exceeding ACK_TIMEOUT clocks without pulser_ready=0 SHALL set timeout=1 and go FINISH (done pulses); timeout stays set until next accepted start or reset.
REQ-023 Without SCAN_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely; timeout output SHALL be tied 0.

Verification
REQ-024 start, num_pulses=2, strip_first=3, strip_last=4, model injector (ready low 6 clocks) -> 4 fire_pulse, halfstrips_expect 0x8,0x8,0x10,0x10, done once, timeout=0.
REQ-025 start, num_pulses=0 -> done 1 clock later, zero fire_pulse; strip_first=5, strip_last=2 -> same.
REQ-026 abort during WAIT_DONE of 2nd pulse -> busy=0 next clock, no done, no further fire_pulse; subsequent start runs normally.
REQ-027 SCAN_TIMEOUT_EN defined, pulser_ready held 1 -> timeout=1 after ACK_TIMEOUT clocks, done pulses; undefined -> busy remains 1 indefinitely, timeout=0.
REQ-028 rst_n low mid-SETTLE -> all outputs 0 asynchronously; start during busy ignored; strip_first=strip_last=31, num_pulses=1 -> one fire_pulse, halfstrips_expect=0x80000000.
